// File: rtl/prob2_parta.sv
// Loadable up/down counter with count enable, synchronous active-low clear and
// a combinational terminal-count flag. Define COUNTER_SATURATE_EN to saturate instead of wrap.
module prob2_parta #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic             load,
    input  logic             up,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             Co
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic at_top;
    logic at_bottom;

    // Next count for one enabled step; wraps or clamps at the ends.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] q, input logic dir);
`ifdef COUNTER_SATURATE_EN
        if (dir && (q == ALL_ONES))
            return q;
        else if (!dir && (q == ZERO))
            return q;
        else
            return dir ? (q + ONE) : (q - ONE);
`else
        return dir ? (q + ONE) : (q - ONE);
`endif
    endfunction

    assign at_top    = (Q == ALL_ONES);
    assign at_bottom = (Q == ZERO);

    // Flag looks at the live inputs so it leads the wrap by one cycle; clear masks it.
    assign Co = clr & enable & ~load & ((up & at_top) | (~up & at_bottom));

    always_ff @(posedge clk) begin
        if (!clr)
            Q <= ZERO;
        else if (load)
            Q <= D;
        else if (enable)
            Q <= step(Q, up);
    end

endmodule

// File: tb/tb_prob2_parta.sv
// Directed bench for prob2_parta (default WIDTH=4); expectations follow the
// COUNTER_SATURATE_EN build when that macro is defined.
module tb_prob2_parta;

    logic       clk;
    logic       clr;
    logic       enable;
    logic       load;
    logic       up;
    logic [3:0] D;
    logic [3:0] Q;
    logic       Co;

    int checks;
    int errors;

    prob2_parta #(.WIDTH(4)) dut (
        .clk    (clk),
        .clr    (clr),
        .enable (enable),
        .load   (load),
        .up     (up),
        .D      (D),
        .Q      (Q),
        .Co     (Co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Change inputs and let the combinational flag settle.
    task automatic drive(input logic c, input logic l, input logic e, input logic u, input logic [3:0] d);
        clr = c; load = l; enable = e; up = u; D = d;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr = 1'b0; load = 1'b1; enable = 1'b0; up = 1'b1; D = 4'd9;

        // Clear beats load.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("clr_q", Q, 0);
            chk("clr_co", Co, 0);
        end

        // Load 6 with enable high, then count up.
        drive(1, 1, 1, 1, 4'd6);
        chk("load_co_masked", Co, 0);
        tick();
        chk("load6", Q, 6);
        drive(1, 0, 1, 1, 4'd6);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("up_q", Q, 7 + i);
            chk("up_co", Co, 0);
        end

        // Carry and wrap at the top.
        drive(1, 1, 1, 1, 4'd14);
        tick();
        chk("load14", Q, 14);
        drive(1, 0, 1, 1, 4'd14);
        chk("co_at14", Co, 0);
        tick();
        chk("q15", Q, 15);
        chk("carry", Co, 1);
        tick();
`ifdef COUNTER_SATURATE_EN
        chk("top_sat_q", Q, 15);
        chk("top_sat_co", Co, 1);
`else
        chk("wrap_q", Q, 0);
        chk("wrap_co", Co, 0);
`endif

        // Borrow and wrap at the bottom.
        drive(1, 1, 1, 0, 4'd1);
        tick();
        chk("load1", Q, 1);
        drive(1, 0, 1, 0, 4'd1);
        tick();
        chk("q0", Q, 0);
        chk("borrow", Co, 1);
        tick();
`ifdef COUNTER_SATURATE_EN
        chk("bot_sat_q", Q, 0);
        chk("bot_sat_co", Co, 1);
`else
        chk("borrow_wrap_q", Q, 15);
        chk("borrow_wrap_co", Co, 0);
`endif

        // Hold with enable low while up toggles, then load with enable low.
        drive(1, 1, 0, 1, 4'd10);
        tick();
        chk("load10", Q, 10);
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, i[0], 4'd10);
            tick();
            chk("hold_q", Q, 10);
            chk("hold_co", Co, 0);
        end
        drive(1, 1, 0, 0, 4'd3);
        tick();
        chk("load3_noen", Q, 3);

        // Clear masks an active carry combinationally.
        drive(1, 1, 1, 1, 4'd15);
        tick();
        drive(1, 0, 1, 1, 4'd15);
        chk("co_pre_clr", Co, 1);
        drive(0, 0, 1, 1, 4'd15);
        chk("co_forced_clr", Co, 0);
        tick();
        chk("clr_from15", Q, 0);

        // Clear mid-count, then count down from zero.
        drive(1, 1, 1, 1, 4'd6);
        tick();
        drive(1, 0, 1, 1, 4'd6);
        tick();
        chk("mid_q7", Q, 7);
        tick();
        chk("mid_q8", Q, 8);
        drive(0, 0, 1, 1, 4'd6);
        tick();
        chk("mid_clr_q", Q, 0);
        drive(1, 0, 1, 0, 4'd6);
        chk("mid_borrow_co", Co, 1);
        tick();
`ifdef COUNTER_SATURATE_EN
        chk("mid_down_q", Q, 0);
`else
        chk("mid_down_q", Q, 15);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
